// File: rtl/cic_decim_var_if.sv
// cic_decim_var_if: sample/rate bus for cic_decim_var.
// With CIC_GAIN_EN defined the bus also carries the 2-bit output gain.
interface cic_decim_var_if #(
    parameter int CHANNELS = 2,
    parameter int IN_WIDTH = 18,
    parameter int OUT_WIDTH = 20,
    parameter int RL_WIDTH = 3
);
    logic [RL_WIDTH-1:0] rate_log2;
    logic in_strobe;
    logic [CHANNELS*IN_WIDTH-1:0] in_data;
    logic out_strobe;
    logic [CHANNELS*OUT_WIDTH-1:0] out_data;
    logic settling;
`ifdef CIC_GAIN_EN
    logic [1:0] gain;
    modport master(output rate_log2, in_strobe, in_data, gain, input out_strobe, out_data, settling);
    modport slave(input rate_log2, in_strobe, in_data, gain, output out_strobe, out_data, settling);
`else
    modport master(output rate_log2, in_strobe, in_data, input out_strobe, out_data, settling);
    modport slave(input rate_log2, in_strobe, in_data, output out_strobe, out_data, settling);
`endif
endinterface

// File: rtl/cic_decim_var.sv
// cic_decim_var: multi-channel CIC decimator, R = 2^rate_log2 chosen at run time, R-independent gain.
// Macro CIC_GAIN_EN adds a 2-bit saturating output gain and one extra output register stage.
module cic_decim_var #(
    parameter int STAGES = 3,
    parameter int MAX_DECIMATION = 64,
    parameter int IN_WIDTH = 18,
    parameter int OUT_WIDTH = 20,
    parameter int CHANNELS = 2,
    parameter int RL_WIDTH = 3,
    parameter int ACC_WIDTH = IN_WIDTH + STAGES * $clog2(MAX_DECIMATION)
) (
    input logic clock,
    input logic reset,
    cic_decim_var_if.slave bus
);
    localparam int MAXR = $clog2(MAX_DECIMATION);
    localparam int SCW = $clog2(STAGES + 1);

    logic [RL_WIDTH-1:0] eff_rate, active_rate;
    logic [MAXR-1:0] cnt, last;
    logic [SCW-1:0] settle_cnt;
    logic dec_tick, flush, settling;
    logic [7:0] sh;
    logic signed [ACC_WIDTH-1:0] integ [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0] dly [CHANNELS][STAGES];
    logic signed [ACC_WIDTH-1:0] cv [CHANNELS][STAGES+1];
    logic signed [ACC_WIDTH-1:0] x [CHANNELS];
    logic signed [ACC_WIDTH-1:0] tmp [CHANNELS];

    assign eff_rate = bus.rate_log2 == '0 ? RL_WIDTH'(1) :
                      bus.rate_log2 > RL_WIDTH'(MAXR) ? RL_WIDTH'(MAXR) : bus.rate_log2;
    // A rate change is handled exactly like a reset so the filter restarts from a clean history.
    assign flush = reset || eff_rate != active_rate;
    assign last = ~({MAXR{1'b1}} << active_rate);
    assign settling = settle_cnt != '0;
    assign bus.settling = settling;

    always_comb begin
        sh = 8'(STAGES) * 8'(active_rate) - 8'(OUT_WIDTH - IN_WIDTH + 1);
        for (int c = 0; c < CHANNELS; c++) begin
            x[c] = ACC_WIDTH'(signed'(bus.in_data[c*IN_WIDTH +: IN_WIDTH]));
            cv[c][0] = integ[c][STAGES-1];
            for (int s = 0; s < STAGES; s++) cv[c][s+1] = cv[c][s] - dly[c][s];
            tmp[c] = cv[c][STAGES] >>> sh;
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            for (int c = 0; c < CHANNELS; c++)
                for (int s = 0; s < STAGES; s++) begin
                    integ[c][s] <= '0;
                    dly[c][s] <= '0;
                end
            cnt <= '0;
            dec_tick <= 1'b0;
            settle_cnt <= SCW'(STAGES);
            active_rate <= eff_rate;
        end else begin
            if (bus.in_strobe) begin
                for (int c = 0; c < CHANNELS; c++) begin
                    integ[c][0] <= integ[c][0] + x[c];
                    for (int s = 1; s < STAGES; s++) integ[c][s] <= integ[c][s] + integ[c][s-1];
                end
                cnt <= cnt == last ? '0 : cnt + MAXR'(1);
            end
            dec_tick <= bus.in_strobe && cnt == last;
            if (dec_tick) begin
                for (int c = 0; c < CHANNELS; c++)
                    for (int s = 0; s < STAGES; s++) dly[c][s] <= cv[c][s];
                if (settling) settle_cnt <= settle_cnt - SCW'(1);
            end
        end
    end

`ifdef CIC_GAIN_EN
    localparam logic signed [ACC_WIDTH+3:0] MAXV = (ACC_WIDTH+4)'(2**(OUT_WIDTH-1) - 1);
    localparam logic signed [ACC_WIDTH+3:0] MINV = -MAXV - 1;

    logic signed [ACC_WIDTH:0] rnd [CHANNELS];
    logic signed [ACC_WIDTH:0] rnd_q [CHANNELS];
    logic signed [ACC_WIDTH+3:0] amp [CHANNELS];
    logic [CHANNELS*OUT_WIDTH-1:0] sat;
    logic [1:0] gain_q;
    logic pend, pend_ok;

    // Rounded value kept one bit wider than the accumulator so the gain path never wraps.
    always_comb begin
        sat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            rnd[c] = {{2{tmp[c][ACC_WIDTH-1]}}, tmp[c][ACC_WIDTH-1:1]} + {{ACC_WIDTH{1'b0}}, tmp[c][0]};
            amp[c] = {{3{rnd_q[c][ACC_WIDTH]}}, rnd_q[c]} <<< gain_q;
            sat[c*OUT_WIDTH +: OUT_WIDTH] = amp[c] > MAXV ? MAXV[OUT_WIDTH-1:0] :
                                            amp[c] < MINV ? MINV[OUT_WIDTH-1:0] : amp[c][OUT_WIDTH-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            for (int c = 0; c < CHANNELS; c++) rnd_q[c] <= '0;
            gain_q <= '0;
            pend <= 1'b0;
            pend_ok <= 1'b0;
            bus.out_strobe <= 1'b0;
            bus.out_data <= '0;
        end else begin
            pend <= dec_tick;
            if (dec_tick) begin
                for (int c = 0; c < CHANNELS; c++) rnd_q[c] <= rnd[c];
                gain_q <= bus.gain;
                pend_ok <= !settling;
            end
            bus.out_strobe <= pend && pend_ok;
            if (pend) bus.out_data <= sat;
        end
    end
`else
    logic [CHANNELS*OUT_WIDTH-1:0] out_next;

    // Round half up: tmp holds the result scaled by 2, its LSB is the rounding bit.
    always_comb begin
        out_next = '0;
        for (int c = 0; c < CHANNELS; c++)
            out_next[c*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(tmp[c] >>> 1) + OUT_WIDTH'(tmp[c][0]);
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            bus.out_strobe <= 1'b0;
            bus.out_data <= '0;
        end else begin
            bus.out_strobe <= dec_tick && !settling;
            if (dec_tick) bus.out_data <= out_next;
        end
    end
`endif
endmodule

// File: tb/tb_cic_decim_var.sv
// tb_cic_decim_var: directed vector table plus hand sequences for latency, rate step, reset and rounding.
module tb_cic_decim_var;
    localparam int IW = 18;
    localparam int OW = 20;
`ifdef CIC_GAIN_EN
    localparam int LAT = 3;
    localparam int NV = 7;
`else
    localparam int LAT = 2;
    localparam int NV = 6;
`endif

    typedef struct {
        logic [2:0] rate;
        int d0, d1, n, gap, outs, e0, e1;
        logic [1:0] gain;
    } vec_t;

    logic clk, reset;
    int total, bad, n_out, last0, last1, n0;
    vec_t vecs [NV];

    cic_decim_var_if #(.CHANNELS(2), .IN_WIDTH(IW), .OUT_WIDTH(OW), .RL_WIDTH(3)) bus ();
    cic_decim_var dut (.clock(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.out_strobe) begin
            n_out++;
            last0 = int'($signed(bus.out_data[OW-1:0]));
            last1 = int'($signed(bus.out_data[2*OW-1:OW]));
        end

    task automatic chk(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_in(int d0, int d1);
        bus.in_data = {18'(d1), 18'(d0)};
    endtask

    task automatic reset_dut(logic [2:0] r, int d0, int d1, logic [1:0] g);
        bus.rate_log2 = r;
        set_in(d0, d1);
`ifdef CIC_GAIN_EN
        bus.gain = g;
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        n_out = 0;
    endtask

    task automatic feed(int n, int gap);
        for (int i = 0; i < n; i++) begin
            bus.in_strobe = 1'b1;
            @(negedge clk);
            bus.in_strobe = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    task automatic idle();
        repeat (4) @(negedge clk);
        #1;
    endtask

    initial begin
        total = 0; bad = 0; n_out = 0; last0 = 0; last1 = 0;
        bus.in_strobe = 1'b0;
        reset = 1'b0;
        vecs[0] = '{3'd4, 1000, 1000, 96, 4, 3, 4000, 4000, 2'd0};
        vecs[1] = '{3'd6, 131071, 0, 320, 1, 2, 524284, 0, 2'd0};
        vecs[2] = '{3'd6, -131072, -5, 320, 1, 2, -524288, -20, 2'd0};
        vecs[3] = '{3'd0, 1000, -1000, 20, 2, 7, 4000, -4000, 2'd0};
        vecs[4] = '{3'd7, 1000, 1000, 256, 1, 1, 4000, 4000, 2'd0};
        vecs[5] = '{3'd3, -1000, 12345, 40, 1, 2, -4000, 49380, 2'd0};
`ifdef CIC_GAIN_EN
        vecs[6] = '{3'd4, 100000, -1000, 96, 2, 3, 524287, -32000, 2'd3};
`endif

        reset_dut(3'd4, 1000, 1000, 2'd0);
        chk("reset out_strobe", int'(bus.out_strobe), 0);
        chk("reset out_data", int'(bus.out_data != '0), 0);
        chk("reset settling", int'(bus.settling), 1);

        for (int i = 0; i < NV; i++) begin
            reset_dut(vecs[i].rate, vecs[i].d0, vecs[i].d1, vecs[i].gain);
            feed(vecs[i].n, vecs[i].gap);
            idle();
            chk($sformatf("vec%0d outs", i), n_out, vecs[i].outs);
            chk($sformatf("vec%0d ch0", i), last0, vecs[i].e0);
            chk($sformatf("vec%0d ch1", i), last1, vecs[i].e1);
        end

        // settling release and completing-strobe latency at R=16
        reset_dut(3'd4, 1000, 1000, 2'd0);
        feed(47, 4);
        idle();
        chk("settling before 3rd tick", int'(bus.settling), 1);
        feed(1, 4);
        idle();
        chk("settling after 3rd tick", int'(bus.settling), 0);
        chk("suppressed outs", n_out, 0);
        feed(15, 4);
        bus.in_strobe = 1'b1;
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            bus.in_strobe = 1'b0;
            chk($sformatf("latency clk%0d", k), int'(bus.out_strobe), int'(k == LAT));
        end
        chk("latency data", int'($signed(bus.out_data[OW-1:0])), 4000);

        // rate step 4 -> 2 with a strobe in the switch cycle
        feed(5, 4);
        bus.rate_log2 = 3'd2;
        bus.in_strobe = 1'b1;
        @(negedge clk);
        bus.in_strobe = 1'b0;
        chk("step settling", int'(bus.settling), 1);
        n0 = n_out;
        feed(15, 2);
        idle();
        chk("step discard", n_out - n0, 0);
        feed(1, 2);
        idle();
        chk("step first out", n_out - n0, 1);
        chk("step data", last0, 4000);

        // reset mid-decimation at count 9
        reset_dut(3'd4, 1000, 1000, 2'd0);
        feed(64, 2);
        idle();
        feed(9, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midreset out_data", int'(bus.out_data != '0), 0);
        chk("midreset settling", int'(bus.settling), 1);
        chk("midreset strobe", int'(bus.out_strobe), 0);
        n0 = n_out;
        feed(47, 2);
        idle();
        chk("midreset suppressed", n_out - n0, 0);
        feed(17, 2);
        idle();
        chk("midreset resumed", n_out - n0, 1);
        chk("midreset settled", int'(bus.settling), 0);

        // rounding of the first (suppressed) output: +8/16 -> 1, -8/16 -> 0
        reset_dut(3'd2, 2, -2, 2'd0);
        feed(4, 2);
        repeat (3) @(negedge clk);
        chk("round ch0", int'($signed(bus.out_data[OW-1:0])), 1);
        chk("round ch1", int'($signed(bus.out_data[2*OW-1:OW])), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
